// File: rtl/write_image.sv
// write_image
//   Streams NUM_BYTES image bytes from a valid/ready source into a memory
//   write port, one address per byte starting at 0, and keeps a running
//   16-bit checksum of the frame.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      single-cycle request to begin a frame (honoured in IDLE only)
//   in_valid   source has a byte on in_data
//   in_data    image byte
//   in_ready   block accepts a byte this cycle (WRITE state)
//   mem_we     memory write strobe, one cycle after each accepted byte
//   mem_addr   memory write address
//   mem_wdata  memory write data
//   busy       frame in progress (WRITE or DONE)
//   done       one-cycle pulse aligned with the last byte's write strobe
//   checksum   modulo-2^16 sum of the bytes of the current or last frame
module write_image #(
  parameter int NUM_BYTES = 200,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t              state_r;
  state_t              state_next_s;
  logic [ADDR_W-1:0]   count_r;
  logic [15:0]         checksum_r;
  logic                xfer_s;
  logic                frame_start_s;

  assign checksum = checksum_r;

  // Next-state logic and state decodes for in_ready/busy/done.
  always_comb begin
    state_next_s  = state_r;
    xfer_s        = 1'b0;
    frame_start_s = 1'b0;
    in_ready      = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          frame_start_s = 1'b1;
          state_next_s  = WRITE;
        end else begin
          state_next_s  = IDLE;
        end
      end
      WRITE: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        xfer_s   = in_valid;
        // The byte landing at the last address closes the frame.
        if (in_valid && (count_r == LAST_ADDR)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = WRITE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Byte counter and checksum; both cleared when a frame is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r    <= '0;
      checksum_r <= 16'h0000;
    end else if (frame_start_s) begin
      count_r    <= '0;
      checksum_r <= 16'h0000;
    end else if (xfer_s) begin
      count_r    <= count_r + ADDR_ONE;
      checksum_r <= checksum_r + {8'h00, in_data};
    end else begin
      count_r    <= count_r;
      checksum_r <= checksum_r;
    end
  end

  // Registered memory write port; address/data hold while the strobe is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
    end else if (xfer_s) begin
      mem_we    <= 1'b1;
      mem_addr  <= count_r;
      mem_wdata <= in_data;
    end else begin
      mem_we    <= 1'b0;
      mem_addr  <= mem_addr;
      mem_wdata <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_write_image.sv
module tb_write_image;

  // ---------------- small instance: NUM_BYTES=4, ADDR_W=3 ----------------
  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, mem_we, busy, done;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [15:0] checksum;

  // ---------------- large instance: NUM_BYTES=200, ADDR_W=8 --------------
  logic       w_reset, w_start, w_valid;
  logic [7:0] w_data;
  logic       w_ready, w_we, w_busy, w_done;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;
  logic [15:0] w_sum;

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         due;
  } wr_t;

  wr_t sb[$];
  wr_t e;
  int  next_addr;

  write_image #(.NUM_BYTES(4), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .checksum(checksum)
  );

  write_image #(.NUM_BYTES(200), .ADDR_W(8)) dut_big (
    .clk(clk), .reset(w_reset), .start(w_start), .in_valid(w_valid),
    .in_data(w_data), .in_ready(w_ready), .mem_we(w_we),
    .mem_addr(w_addr), .mem_wdata(w_wdata), .busy(w_busy),
    .done(w_done), .checksum(w_sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every write must match the oldest expected entry,
  // in the cycle right after its transfer.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%h at cycle %0d, required no write",
                 mem_addr, mem_wdata, cyc);
      end else begin
        e = sb.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.due) begin
          fails++;
          $display("FAIL write_match: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                   mem_addr, mem_wdata, cyc, e.addr, e.data, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      tests_run++;
      fails++;
      e = sb.pop_front();
      $display("FAIL missing_write: got mem_we=%b at cycle %0d, required write addr=%0d data=%h",
               mem_we, cyc, e.addr, e.data);
    end
  end

  // Drive one cycle of stimulus; acc marks a byte the block must accept.
  task automatic tick(input logic st, input logic v, input logic [7:0] d,
                      input logic rs, input logic acc);
    wr_t w;
    start    = st;
    in_valid = v;
    in_data  = d;
    reset    = rs;
    if (acc) begin
      w.addr = 3'(next_addr);
      w.data = d;
      w.due  = cyc + 1;
      sb.push_back(w);
      next_addr++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tests_run++; if (mem_we !== 1'b0)       begin fails++; $display("FAIL reset_we: got %b, required 0", mem_we); end
    tests_run++; if (mem_addr !== 3'd0)     begin fails++; $display("FAIL reset_addr: got %0d, required 0", mem_addr); end
    tests_run++; if (mem_wdata !== 8'h00)   begin fails++; $display("FAIL reset_wdata: got %h, required 00", mem_wdata); end
    tests_run++; if (done !== 1'b0)         begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
    tests_run++; if (busy !== 1'b0)         begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests_run++; if (in_ready !== 1'b0)     begin fails++; $display("FAIL reset_ready: got %b, required 0", in_ready); end
    tests_run++; if (checksum !== 16'h0000) begin fails++; $display("FAIL reset_sum: got %h, required 0000", checksum); end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [4];
    bytes[0] = 8'h10; bytes[1] = 8'h20; bytes[2] = 8'h30; bytes[3] = 8'h40;
    next_addr = 0;
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tests_run++; if (in_ready !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL basic_write_state: got ready=%b busy=%b, required 1 1", in_ready, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, bytes[i], 1'b0, 1'b1);
      tests_run++; if (done !== (i == 3)) begin
        fails++; $display("FAIL basic_done_%0d: got %b, required %b", i, done, (i == 3));
      end
    end
    tests_run++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL basic_done_state: got ready=%b busy=%b, required 0 1", in_ready, busy);
    end
    tests_run++; if (checksum !== 16'h00A0) begin
      fails++; $display("FAIL basic_sum: got %h, required 00a0", checksum);
    end
    // valid stays high in DONE: nothing more may be consumed
    tick(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL basic_idle: got busy=%b done=%b, required 0 0", busy, done);
    end
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tests_run++; if (checksum !== 16'h00A0) begin
      fails++; $display("FAIL basic_sum_hold: got %h, required 00a0", checksum);
    end
  endtask

  task automatic test_stall();
    logic [6:0] pat;
    int ndone;
    logic [15:0] exp_sum;
    pat = 7'b1101001;  // applied LSB first: 1,0,0,1,0,1,1
    ndone = 0;
    exp_sum = 16'h0000;
    next_addr = 0;
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) exp_sum = exp_sum + {8'h00, 8'(8'hA0 + i)};
      tick(1'b0, pat[i], 8'(8'hA0 + i), 1'b0, pat[i]);
      if (done === 1'b1) ndone++;
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
      if (done === 1'b1) ndone++;
    end
    tests_run++; if (ndone != 1) begin fails++; $display("FAIL stall_done_count: got %0d, required 1", ndone); end
    tests_run++; if (checksum !== exp_sum) begin
      fails++; $display("FAIL stall_sum: got %h, required %h", checksum, exp_sum);
    end
  endtask

  task automatic test_start_ignored();
    next_addr = 0;
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);  // start in WRITE: must not restart
    tick(1'b0, 1'b1, 8'h44, 1'b0, 1'b1);
    tests_run++; if (done !== 1'b1) begin fails++; $display("FAIL ign_done: got %b, required 1", done); end
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);  // start in DONE: ignored
    tests_run++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL ign_idle: got busy=%b ready=%b, required 0 0", busy, in_ready);
    end
    tick(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL ign_no_frame: got busy=%b, required 0", busy); end
    tests_run++; if (checksum !== 16'h00AA) begin
      fails++; $display("FAIL ign_sum: got %h, required 00aa", checksum);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    next_addr = 0;
    ndone = 0;
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 8'h03, 1'b1, 1'b0);  // reset beats start and transfer
    tests_run++; if (mem_we !== 1'b0 || mem_addr !== 3'd0 || mem_wdata !== 8'h00) begin
      fails++; $display("FAIL mid_reset_port: got we=%b addr=%0d data=%h, required 0 0 00", mem_we, mem_addr, mem_wdata);
    end
    tests_run++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || checksum !== 16'h0000) begin
      fails++; $display("FAIL mid_reset_ctl: got busy=%b done=%b ready=%b sum=%h, required 0 0 0 0000",
                        busy, done, in_ready, checksum);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
      if (done === 1'b1) ndone++;
    end
    tests_run++; if (ndone != 0) begin fails++; $display("FAIL mid_no_done: got %0d pulses, required 0", ndone); end
    next_addr = 0;
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b1);
    tests_run++; if (done !== 1'b1 || checksum !== 16'h0306) begin
      fails++; $display("FAIL mid_refill: got done=%b sum=%h, required 1 0306", done, checksum);
    end
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_idle_guard();
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      if (in_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests_run++; if (bad != 0) begin
      fails++; $display("FAIL idle_guard: got %0d active cycles, required 0", bad);
    end
  endtask

  task automatic test_checksum_wrap();
    int ndone;
    int bad;
    ndone = 0;
    bad = 0;
    w_reset = 1'b1; w_start = 1'b0; w_valid = 1'b0; w_data = 8'hFF;
    @(posedge clk); @(negedge clk);
    w_reset = 1'b0; w_start = 1'b1;
    @(posedge clk); @(negedge clk);
    w_start = 1'b0; w_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); @(negedge clk);
      if (w_done === 1'b1) ndone++;
      if (w_we !== 1'b1 || w_addr !== 8'(k) || w_wdata !== 8'hFF) bad++;
    end
    tests_run++; if (bad != 0) begin fails++; $display("FAIL wrap_writes: got %0d bad writes, required 0", bad); end
    w_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    if (w_done === 1'b1) ndone++;
    tests_run++; if (ndone != 1) begin fails++; $display("FAIL wrap_done_count: got %0d, required 1", ndone); end
    tests_run++; if (w_sum !== 16'hC738) begin fails++; $display("FAIL wrap_sum: got %h, required c738", w_sum); end
    tests_run++; if (w_addr !== 8'd199 || w_we !== 1'b0 || w_busy !== 1'b0) begin
      fails++; $display("FAIL wrap_end: got addr=%0d we=%b busy=%b, required 199 0 0", w_addr, w_we, w_busy);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    w_reset = 1'b1; w_start = 1'b0; w_valid = 1'b0; w_data = 8'h00;
    next_addr = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_idle_guard();
    test_checksum_wrap();
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tests_run++; if (sb.size() != 0) begin
      fails++; $display("FAIL sb_drain: got %0d pending writes, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/write_image.md
WRITE_IMAGE -- requirements
Module: write_image

Interface
REQ-001 Parameter NUM_BYTES, default 200: number of image bytes written per frame.
REQ-002 Parameter ADDR_W, default 8: memory address width; SHALL satisfy 2^ADDR_W >= NUM_BYTES.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  single-cycle request to begin a frame write.
REQ-006 in_valid  input  1  source presents a valid byte on in_data.
REQ-007 in_data  input  8  image byte from the source.
REQ-008 in_ready  output  1  block accepts a byte this cycle.
REQ-009 mem_we  output  1  write strobe to image memory.
REQ-010 mem_addr  output  ADDR_W  write address.
REQ-011 mem_wdata  output  8  write data.
REQ-012 busy  output  1  frame write in progress.
REQ-013 done  output  1  one-cycle pulse, frame complete.
REQ-014 checksum  output  16  modulo-2^16 sum of the bytes in the current or last frame.

Function
REQ-015 The FSM SHALL have three states: IDLE, WRITE, DONE.
REQ-016 IDLE -> WRITE when start=1; byte counter and checksum cleared to 0 on that same edge.
REQ-017 In IDLE and DONE, start=0 keeps IDLE; a start asserted in WRITE or DONE SHALL be ignored.
REQ-018 in_ready SHALL be 1 only in WRITE, decoded combinationally from state.
REQ-019 A transfer occurs on any edge where in_valid=1 and in_ready=1; no other byte is consumed.
REQ-020 Each transfer SHALL produce, on the next cycle, mem_we=1, mem_addr=counter value at transfer, mem_wdata=transferred byte (1-cycle latency, registered outputs).
REQ-021 mem_we SHALL be 0 in every cycle not following a transfer; mem_addr/mem_wdata hold their last values while mem_we=0.
REQ-022 The counter increments by 1 per transfer; addresses are 0..NUM_BYTES-1 in order, with no gaps or repeats.
REQ-023 The checksum adds each transferred byte (zero-extended) on the transfer edge, wrapping mod 2^16.
REQ-024 The transfer with counter=NUM_BYTES-1 SHALL move WRITE -> DONE; in_ready is 0 from the next cycle.
REQ-025 DONE lasts exactly one cycle, then IDLE; done=1 only in DONE, coinciding with mem_we of the last byte.
REQ-026 busy SHALL be 1 in WRITE and DONE, 0 in IDLE.
REQ-027 Source stalls (in_valid=0) SHALL not affect counter, checksum or state; there is no timeout.
REQ-028 checksum holds its final value in IDLE until the next accepted start.

Reset
REQ-029 reset=1 at a rising edge SHALL force state IDLE, counter 0, checksum 0, mem_we 0, mem_addr 0, mem_wdata 0, done 0, busy 0; in_ready is 0 in the following cycle.
REQ-030 reset SHALL take priority over start and over any transfer on the same edge.
REQ-031 reset mid-frame SHALL abandon the frame: no done pulse and no further mem_we; the next frame restarts at address 0.

Verification (NUM_BYTES=4, ADDR_W=3 unless noted)
REQ-032 Basic frame: start, then in_valid held high with bytes 0x10,0x20,0x30,0x40 -> mem_we on 4 consecutive cycles at addr 0..3 with those data; done with the addr-3 write; checksum=0x00A0; busy 0 the cycle after done.
REQ-033 Stalled source: in_valid toggled 1,0,0,1,0,1,1 -> exactly 4 writes, each 1 cycle after its transfer, addresses contiguous, done once.
REQ-034 Start ignored: pulse start again during WRITE and during DONE -> no counter reset, no second frame; IDLE reached as normal.
REQ-035 Reset mid-frame: reset after 2 transfers -> all outputs at reset values, no done; new start with 4 bytes writes addr 0..3.
REQ-036 Checksum wrap: NUM_BYTES=200, all bytes 0xFF -> checksum=0xC738 (51000 mod 65536), final mem_addr=199, single done pulse.
REQ-037 Idle guard: in_valid=1 with no start for 10 cycles -> in_ready=0, mem_we=0 throughout.
